// File: rtl/rob_alloc.sv
// rob_alloc: in-order reorder-buffer allocation controller.
// Owns head/tail pointers (with wrap bit) and the live-entry count, hands
// out robids to decode, retires from the head, and holds rob_flush high for
// FLUSH_CYCLES cycles after a retiring entry requests a pipeline flush.
//
// Handshake: an allocation is accepted in any cycle where decode_rob_valid
// is high and rob_full is low; the accepted entry takes the robid shown on
// rob_robid in that same cycle. A retire is accepted when retire_valid is
// high, the ROB is not empty and no flush is in progress. rob_full,
// rob_empty, rob_flush, rob_robid, rob_head and rob_count come straight from
// registers, so none of them depends combinationally on an input.
module rob_alloc #(
    parameter int ROB_IDW      = 7,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               decode_rob_valid,
    output logic               rob_full,
    output logic [ROB_IDW-1:0] rob_robid,
    input  logic               retire_valid,
    input  logic               retire_flush,
    output logic               rob_flush,
    output logic [ROB_IDW-1:0] rob_head,
    output logic               rob_empty,
    output logic [ROB_IDW:0]   rob_count
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Count value meaning "every slot occupied" (2**ROB_IDW).
    localparam logic [ROB_IDW:0] CNT_FULL   = {1'b1, {ROB_IDW{1'b0}}};
    localparam logic [ROB_IDW:0] ONE        = {{ROB_IDW{1'b0}}, 1'b1};
    localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    state_t           state_q, state_d;
    logic [ROB_IDW:0] head_q, head_d;
    logic [ROB_IDW:0] tail_q, tail_d;
    logic [ROB_IDW:0] count_q, count_d;
    logic [3:0]       fcnt_q, fcnt_d;

    logic alloc;
    logic ret;

    // Register-only outputs.
    always_comb begin
        rob_full  = (count_q == CNT_FULL) || (state_q == ST_FLUSH);
        rob_flush = (state_q == ST_FLUSH);
        rob_empty = (count_q == '0);
        rob_robid = tail_q[ROB_IDW-1:0];
        rob_head  = head_q[ROB_IDW-1:0];
        rob_count = count_q;
    end

    // Next-state logic: allocation/retire bookkeeping and flush sequencing.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        fcnt_d  = fcnt_q;

        alloc = decode_rob_valid && !rob_full;
        ret   = retire_valid && !rob_empty && (state_q == ST_RUN);

        case (state_q)
            ST_RUN: begin
                if (ret && retire_flush) begin
                    // Everything younger than the retiring entry is discarded,
                    // including any allocation accepted this same cycle.
                    head_d  = head_q + ONE;
                    tail_d  = head_q + ONE;
                    count_d = '0;
                    fcnt_d  = FLUSH_INIT;
                    state_d = ST_FLUSH;
                end else begin
                    if (alloc) begin
                        tail_d = tail_q + ONE;
                    end
                    if (ret) begin
                        head_d = head_q + ONE;
                    end
                    if (alloc && !ret) begin
                        count_d = count_q + ONE;
                    end else if (ret && !alloc) begin
                        count_d = count_q - ONE;
                    end
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            fcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fcnt_q  <= fcnt_d;
        end
    end

endmodule

// File: tb/tb_rob_alloc.sv
// Directed + short random bench for rob_alloc. A small behavioural model
// tracks head/tail/count/flush; expected robids are queued when an
// allocation is driven and popped when checked against rob_robid.
module tb_rob_alloc;

    localparam int ROB_IDW      = 7;
    localparam int FLUSH_CYCLES = 2;
    localparam int DEPTH        = 1 << ROB_IDW;

    logic               clk;
    logic               rst;
    logic               decode_rob_valid;
    logic               rob_full;
    logic [ROB_IDW-1:0] rob_robid;
    logic               retire_valid;
    logic               retire_flush;
    logic               rob_flush;
    logic [ROB_IDW-1:0] rob_head;
    logic               rob_empty;
    logic [ROB_IDW:0]   rob_count;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_head;   // modulo 2*DEPTH
    int m_tail;   // modulo 2*DEPTH
    int m_count;
    int m_fl;     // flush cycles still to show

    logic [ROB_IDW-1:0] exp_q[$];

    rob_alloc #(
        .ROB_IDW     (ROB_IDW),
        .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .decode_rob_valid(decode_rob_valid),
        .rob_full        (rob_full),
        .rob_robid       (rob_robid),
        .retire_valid    (retire_valid),
        .retire_flush    (retire_flush),
        .rob_flush       (rob_flush),
        .rob_head        (rob_head),
        .rob_empty       (rob_empty),
        .rob_count       (rob_count)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_head  = 0;
        m_tail  = 0;
        m_count = 0;
        m_fl    = 0;
        exp_q.delete();
    endtask

    task automatic check_state(input string where);
        check({where, ":full"},  32'(rob_full),  32'((m_count == DEPTH) || (m_fl > 0)));
        check({where, ":flush"}, 32'(rob_flush), 32'(m_fl > 0));
        check({where, ":empty"}, 32'(rob_empty), 32'(m_count == 0));
        check({where, ":robid"}, 32'(rob_robid), 32'(m_tail % DEPTH));
        check({where, ":head"},  32'(rob_head),  32'(m_head % DEPTH));
        check({where, ":count"}, 32'(rob_count), 32'(m_count));
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, ":full"},  32'(rob_full),  32'd0);
        check({where, ":flush"}, 32'(rob_flush), 32'd0);
        check({where, ":empty"}, 32'(rob_empty), 32'd1);
        check({where, ":robid"}, 32'(rob_robid), 32'd0);
        check({where, ":head"},  32'(rob_head),  32'd0);
        check({where, ":count"}, 32'(rob_count), 32'd0);
    endtask

    // Called right after a falling edge: drive inputs, score any accepted
    // allocation, clock once, update the model, check on the next falling edge.
    task automatic step(input logic dv, input logic rv, input logic rf);
        logic m_full, m_alloc, m_ret;
        decode_rob_valid = dv;
        retire_valid     = rv;
        retire_flush     = rf;
        m_full  = (m_count == DEPTH) || (m_fl > 0);
        m_alloc = dv && !m_full;
        m_ret   = rv && (m_count != 0) && (m_fl == 0);
        if (m_alloc) begin
            exp_q.push_back(ROB_IDW'(m_tail % DEPTH));
        end
        if (exp_q.size() != 0) begin
            check("alloc_robid", 32'(rob_robid), 32'(exp_q.pop_front()));
        end
        @(posedge clk);
        if (m_fl > 0) begin
            m_fl = m_fl - 1;
        end else if (m_ret && rf) begin
            m_head  = (m_head + 1) % (2 * DEPTH);
            m_tail  = m_head;
            m_count = 0;
            m_fl    = FLUSH_CYCLES;
        end else begin
            if (m_alloc) begin
                m_tail  = (m_tail + 1) % (2 * DEPTH);
                m_count = m_count + 1;
            end
            if (m_ret) begin
                m_head  = (m_head + 1) % (2 * DEPTH);
                m_count = m_count - 1;
            end
        end
        @(negedge clk);
        check_state("step");
    endtask

    task automatic apply_reset();
        decode_rob_valid = 1'b0;
        retire_valid     = 1'b0;
        retire_flush     = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_state("post_reset");
    endtask

    initial begin
        rst              = 1'b0;
        decode_rob_valid = 1'b0;
        retire_valid     = 1'b0;
        retire_flush     = 1'b0;
        model_reset();

        // 1: reset, then fill for 130 cycles with no retires
        apply_reset();
        for (int i = 0; i < 130; i++) begin
            step(1'b1, 1'b0, 1'b0);
        end
        check("fill:full",  32'(rob_full),  32'd1);
        check("fill:count", 32'(rob_count), 32'd128);
        check("fill:robid", 32'(rob_robid), 32'd0);

        // 2: retire from full while decode keeps requesting
        step(1'b1, 1'b1, 1'b0);
        check("fullret1:count", 32'(rob_count), 32'd127);
        check("fullret1:head",  32'(rob_head),  32'd1);
        check("fullret2:robid_offered", 32'(rob_robid), 32'd0);
        step(1'b1, 1'b1, 1'b0);
        check("fullret2:count", 32'(rob_count), 32'd127);
        check("fullret2:robid", 32'(rob_robid), 32'd1);

        // 3: count=5 head=3 tail=8, then 4 cycles of alloc+retire
        apply_reset();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        check("steady_pre:count", 32'(rob_count), 32'd5);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0);
        check("steady:count", 32'(rob_count), 32'd5);
        check("steady:head",  32'(rob_head),  32'd7);
        check("steady:tail",  32'(rob_robid), 32'd12);

        // 4: flush with count=10 head=3
        apply_reset();
        for (int i = 0; i < 13; i++) step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        check("flush_pre:count", 32'(rob_count), 32'd10);
        step(1'b1, 1'b1, 1'b1);
        check("flush1:head",  32'(rob_head),  32'd4);
        check("flush1:tail",  32'(rob_robid), 32'd4);
        check("flush1:count", 32'(rob_count), 32'd0);
        check("flush1:empty", 32'(rob_empty), 32'd1);
        check("flush1:flush", 32'(rob_flush), 32'd1);
        check("flush1:full",  32'(rob_full),  32'd1);
        step(1'b1, 1'b1, 1'b1);
        check("flush2:flush", 32'(rob_flush), 32'd1);
        check("flush2:full",  32'(rob_full),  32'd1);
        check("flush2:robid", 32'(rob_robid), 32'd4);
        step(1'b1, 1'b0, 1'b0);
        check("flush3:flush", 32'(rob_flush), 32'd0);
        check("flush3:full",  32'(rob_full),  32'd0);
        check("flush3:robid", 32'(rob_robid), 32'd4);

        // 5: retire while empty; retire_flush without retire_valid
        apply_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("empty_ret:count", 32'(rob_count), 32'd0);
        check("empty_ret:head",  32'(rob_head),  32'd0);
        check("empty_ret:flush", 32'(rob_flush), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("rf_only:count", 32'(rob_count), 32'd3);
        check("rf_only:head",  32'(rob_head),  32'd0);
        check("rf_only:flush", 32'(rob_flush), 32'd0);

        // 6: asynchronous reset in the first flush cycle
        step(1'b0, 1'b1, 1'b1);
        check("midflush:flush", 32'(rob_flush), 32'd1);
        decode_rob_valid = 1'b0;
        retire_valid     = 1'b0;
        retire_flush     = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        check_state("after_async");
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("after_async:count", 32'(rob_count), 32'd2);

        // 7: short random mix, model-checked every cycle
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 15) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_alloc.md
Name: rob_alloc

Overview:
In-order reorder-buffer allocation controller. It owns the ROB head and tail pointers and the occupancy count, and hands out robids to decode. It retires entries from the head under commit control and sequences a multi-cycle pipeline flush when the retiring instruction requires one. It drives the rob_full, rob_robid and rob_flush signals that decode and rename consume.

Parameters:
ROB_IDW, 7, robid width; ROB depth = 2**ROB_IDW (128)
FLUSH_CYCLES, 2, number of cycles rob_flush is held asserted per flush event; legal range 1..15

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; asynchronous, active-low (0 = reset)
decode_rob_valid  input  1  allocation request from decode; already gated by decode with rename stall
rob_full  output  1  allocation blocked (ROB full or flush in progress)
rob_robid  output  ROB_IDW  robid assigned to the next accepted allocation (tail)
retire_valid  input  1  head entry retires this cycle
retire_flush  input  1  retiring head entry requires a flush; meaningful only with retire_valid
rob_flush  output  1  pipeline flush strobe to fetch/decode/rename
rob_head  output  ROB_IDW  robid of the oldest live entry
rob_empty  output  1  no live entries
rob_count  output  ROB_IDW+1  live entry count, 0..DEPTH

Behaviour:
- State: head and tail pointers, ROB_IDW+1 bits each (MSB is the wrap bit). Count register, ROB_IDW+1 bits. FSM {RUN, FLUSH}. 4-bit flush counter.
- Reset (rst=0, asynchronous):
  - head=tail=0, count=0, FSM=RUN, flush counter=0.
  - Outputs: rob_full=0, rob_flush=0, rob_empty=1, rob_robid=0, rob_head=0, rob_count=0.
- Combinational outputs are derived only from registers, with no input-to-output paths:
  - rob_full = (count==DEPTH) | (FSM==FLUSH)
  - rob_robid = tail[ROB_IDW-1:0]
  - rob_head = head[ROB_IDW-1:0]
  - rob_empty = (count==0)
  - rob_flush = (FSM==FLUSH)
- Allocation accepted (alloc) = decode_rob_valid & ~rob_full. The accepted entry gets the robid shown in that same cycle. tail increments at the edge.
- Retire accepted (ret) = retire_valid & ~rob_empty & (FSM==RUN). head increments at the edge. retire_valid while empty or in FLUSH is ignored with no state change.
- Count update in RUN without flush:
  - alloc only: count+1
  - ret only: count-1
  - both: count unchanged, both pointers advance
- Full plus retire in the same cycle: allocation stays blocked that cycle, because rob_full is register-based. The freed slot becomes usable next cycle.
- Wrap-around: pointers wrap modulo 2*DEPTH. robid wraps from DEPTH-1 to 0 with no bubble.
- Flush (ret & retire_flush) at edge N:
  - head <= head+1, tail <= head+1, count <= 0.
  - Any same-cycle allocation is discarded.
  - FSM <= FLUSH; flush counter <= FLUSH_CYCLES-1.
- FLUSH state:
  - rob_flush=1 and rob_full=1; allocations and retires are ignored.
  - Counter decrements each cycle. When the counter is 0, FSM <= RUN at that edge.
  - rob_flush is therefore high for exactly FLUSH_CYCLES cycles, starting the cycle after edge N.
- retire_flush without retire_valid: ignored.
- Reset asserted mid-FLUSH: immediately returns to the reset state, with rob_flush low asynchronously.
- Latency: a robid is available the cycle after reset release. An allocation's effect on count/full is visible the cycle after acceptance.

Test Plan:
- Reset release, hold decode_rob_valid=1 for 130 cycles with no retires:
  - robids 0..127 accepted; rob_full=1 from cycle 129; rob_count=128; rob_robid=0 (wrapped); cycles 129-130 not accepted.
- From full, retire_valid=1 with decode_rob_valid=1:
  - cycle 1: retire only; count 127, head=1.
  - cycle 2: alloc and retire together; count stays 127, robid 0 issued.
- Count=5, head=3, tail=8; alloc+retire together for 4 cycles:
  - count stays 5; head=7, tail=12; robids 8..11 issued.
- Count=10, head=3; retire_valid=retire_flush=1 with decode_rob_valid=1:
  - next cycle: head=tail=4, count=0, rob_empty=1.
  - rob_flush=1 and rob_full=1 for exactly 2 cycles; no allocation during them.
  - Third cycle: rob_full=0, robid=4.
- retire_valid=1 while empty, and retire_flush=1 with retire_valid=0:
  - no pointer/count change, rob_flush stays 0.
- Drive rst=0 in the middle of cycle 1 of a flush:
  - rob_flush drops before the next clock edge; all outputs at reset values; FSM RUN after release.
